// File: rtl/cla_pipe_addsub_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int CLA_GRP_W = 4;

  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
  } stage_ctrl_t;

  function automatic int calcStages(int width, int segW);
    return width / segW;
  endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/cla_pipe_addsub_seg_adder.sv
// Combinational SEG_W-bit lookahead adder: 4-bit p/g groups feeding a
// parallel-prefix group carry network, so no carry ripples inside the segment.
module cla_seg_adder
  import cla_pkg::*;
#(
  parameter int SEG_W = 32
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  localparam int GW = CLA_GRP_W;
  localparam int NG = SEG_W / GW;
  localparam int LV = (NG > 1) ? $clog2(NG) : 0;

  logic [SEG_W-1:0] p, g, c;
  logic [NG-1:0]    grpP, grpG, preP, preG, grpCin;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    grpP = '0;
    grpG = '0;
    for (int j = 0; j < NG; j++) begin
      grpP[j] = &p[j*GW +: GW];
      grpG[j] = g[j*GW+3]
              | (p[j*GW+3] & g[j*GW+2])
              | (p[j*GW+3] & p[j*GW+2] & g[j*GW+1])
              | ((&p[j*GW+1 +: 3]) & g[j*GW]);
    end
  end

  // Kogge-Stone prefix over groups; descending j keeps the lower operand from the previous level.
  always_comb begin
    preP = grpP;
    preG = grpG;
    for (int l = 0; l < LV; l++) begin
      for (int j = NG - 1; j >= (1 << l); j--) begin
        preG[j] = preG[j] | (preP[j] & preG[j - (1 << l)]);
        preP[j] = preP[j] & preP[j - (1 << l)];
      end
    end
  end

  always_comb begin
    grpCin    = '0;
    grpCin[0] = cin;
    for (int j = 1; j < NG; j++) begin
      grpCin[j] = preG[j-1] | (preP[j-1] & cin);
    end
  end

  always_comb begin
    c = '0;
    for (int j = 0; j < NG; j++) begin
      c[j*GW]   = grpCin[j];
      c[j*GW+1] = g[j*GW] | (p[j*GW] & grpCin[j]);
      c[j*GW+2] = g[j*GW+1] | (p[j*GW+1] & g[j*GW])
                | (p[j*GW+1] & p[j*GW] & grpCin[j]);
      c[j*GW+3] = g[j*GW+2] | (p[j*GW+2] & g[j*GW+1])
                | (p[j*GW+2] & p[j*GW+1] & g[j*GW])
                | ((&p[j*GW +: 3]) & grpCin[j]);
    end
  end

  assign s        = p ^ c;
  assign cout     = preG[NG-1] | (preP[NG-1] & cin);
  assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/sub: one SEG_W segment per stage, carry registered between stages,
// global stall enable driven by the output handshake.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int SEG_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  cla_pipe_addsub_if.slave bus
);

  localparam int STAGES = calcStages(WIDTH, SEG_W);

  if ((WIDTH % SEG_W) != 0 || SEG_W < CLA_GRP_W || (SEG_W & (SEG_W - 1)) != 0) begin : gBadParams
    $error("cla_pipe_addsub: WIDTH must be a multiple of SEG_W, SEG_W a power of 2 and >= 4");
  end

  logic             advance;
  logic             outValid_q;
  logic [WIDTH-1:0] outSum_q;
  logic             outCout_q, outOvf_q, outZero_q;

  assign advance      = !outValid_q || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = outValid_q;
  assign bus.out_sum  = outSum_q;
  assign bus.out_cout = outCout_q;
  assign bus.out_ovf  = outOvf_q;
  assign bus.out_zero = outZero_q;

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    localparam int REM_W = WIDTH - k * SEG_W;

    stage_ctrl_t      ctrlIn;
    logic [REM_W-1:0] aRem, bRem;
    logic [SEG_W-1:0] segB, segS;
    logic             segCout, segCmsb;

    // Stage k sees operand bits from segment k upward; B is kept raw and inverted per segment.
    if (k == 0) begin : gFirst
      assign ctrlIn = '{valid: bus.in_valid, sub: bus.in_sub, carry: bus.in_sub | bus.in_cin};
      assign aRem   = bus.in_a;
      assign bRem   = bus.in_b;
    end else begin : gNext
      assign ctrlIn = gStage[k-1].gMid.ctrl_q;
      assign aRem   = gStage[k-1].gMid.aUp_q;
      assign bRem   = gStage[k-1].gMid.bUp_q;
    end

    assign segB = ctrlIn.sub ? ~bRem[SEG_W-1:0] : bRem[SEG_W-1:0];

    cla_seg_adder #(.SEG_W(SEG_W)) uSegAdder (
      .a        (aRem[SEG_W-1:0]),
      .b        (segB),
      .cin      (ctrlIn.carry),
      .s        (segS),
      .cout     (segCout),
      .c_msb_in (segCmsb)
    );

    if (k < STAGES - 1) begin : gMid
      stage_ctrl_t                ctrl_q, ctrl_d;
      logic [REM_W-SEG_W-1:0]     aUp_q, bUp_q;
      logic [(k+1)*SEG_W-1:0]     sumLow_q, sumLow_d;

      assign ctrl_d = '{valid: ctrlIn.valid, sub: ctrlIn.sub, carry: segCout};

      if (k == 0) begin : gLow0
        assign sumLow_d = segS;
      end else begin : gLowN
        assign sumLow_d = {segS, gStage[k-1].gMid.sumLow_q};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctrl_q <= '0;
        end else if (advance) begin
          ctrl_q <= ctrl_d;
        end
      end

      // Operand and partial-sum data need no reset; the valid bit qualifies them.
      always_ff @(posedge clk) begin
        if (advance) begin
          aUp_q    <= aRem[REM_W-1:SEG_W];
          bUp_q    <= bRem[REM_W-1:SEG_W];
          sumLow_q <= sumLow_d;
        end
      end
    end else begin : gLast
      logic [WIDTH-1:0] sum_d;

      if (k == 0) begin : gSum0
        assign sum_d = segS;
      end else begin : gSumN
        assign sum_d = {segS, gStage[k-1].gMid.sumLow_q};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          outValid_q <= 1'b0;
          outSum_q   <= '0;
          outCout_q  <= 1'b0;
          outOvf_q   <= 1'b0;
          outZero_q  <= 1'b1;
        end else if (advance) begin
          outValid_q <= ctrlIn.valid;
          outSum_q   <= sum_d;
          outCout_q  <= segCout;
          outOvf_q   <= segCout ^ segCmsb;
          outZero_q  <= ~|sum_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: runs the same directed/stream/backpressure/reset suite
// on a 128/32 (4-stage) instance and a 64/64 (1-stage) instance.
module tb_cla_pipe_addsub;

  typedef struct packed {
    logic [127:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk;
  logic rst_n;

  int           cfg;
  int           curW;
  int           curSt;
  logic         inValid, inCin, inSub, outRdy;
  logic [127:0] inA, inB;

  logic         obsValid, obsInReady, obsCout, obsOvf, obsZero;
  logic [127:0] obsSum;

  int   nTests, nFails;
  int   nPushed, nPopped, nDiscard;
  int   cycleNo, lastOut;
  bit   streamMode, haveLast, accepted;
  exp_t sb[$];

  cla_pipe_addsub_if #(.WIDTH(128)) bus0 ();
  cla_pipe_addsub_if #(.WIDTH(64))  bus1 ();

  cla_pipe_addsub #(.WIDTH(128), .SEG_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  cla_pipe_addsub #(.WIDTH(64),  .SEG_W(64)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.in_valid  = inValid & (cfg == 0);
  assign bus0.in_a      = inA;
  assign bus0.in_b      = inB;
  assign bus0.in_cin    = inCin;
  assign bus0.in_sub    = inSub;
  assign bus0.out_ready = outRdy;
  assign bus1.in_valid  = inValid & (cfg == 1);
  assign bus1.in_a      = inA[63:0];
  assign bus1.in_b      = inB[63:0];
  assign bus1.in_cin    = inCin;
  assign bus1.in_sub    = inSub;
  assign bus1.out_ready = outRdy;

  always_comb begin
    if (cfg == 0) begin
      obsValid   = bus0.out_valid;
      obsInReady = bus0.in_ready;
      obsSum     = bus0.out_sum;
      obsCout    = bus0.out_cout;
      obsOvf     = bus0.out_ovf;
      obsZero    = bus0.out_zero;
    end else begin
      obsValid   = bus1.out_valid;
      obsInReady = bus1.in_ready;
      obsSum     = {64'b0, bus1.out_sum};
      obsCout    = bus1.out_cout;
      obsOvf     = bus1.out_ovf;
      obsZero    = bus1.out_zero;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the DUT handshake wedges.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] maskW(int w);
    return (w >= 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: plain wide arithmetic, overflow from operand/result sign bits.
  function automatic exp_t model(logic [127:0] a, logic [127:0] b, logic cin, logic sub);
    exp_t         e;
    logic [128:0] full;
    logic [127:0] m, am, bm;
    m      = maskW(curW);
    am     = a & m;
    bm     = (sub ? ~b : b) & m;
    full   = {1'b0, am} + {1'b0, bm} + {128'b0, (sub ? 1'b1 : cin)};
    e.sum  = full[127:0] & m;
    e.cout = full[curW];
    e.ovf  = (am[curW-1] == bm[curW-1]) && (e.sum[curW-1] != am[curW-1]);
    e.zero = (e.sum == 128'b0);
    return e;
  endfunction

  task automatic checkEq(string tag, logic [127:0] obs, logic [127:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s (cfg%0d): observed %h expected %h", tag, cfg, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checkEq("sb_nonempty", 128'(sb.size() != 0), 128'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      nPopped++;
      checkEq("sum",  obsSum,  e.sum);
      checkEq("cout", 128'(obsCout), 128'(e.cout));
      checkEq("ovf",  128'(obsOvf),  128'(e.ovf));
      checkEq("zero", 128'(obsZero), 128'(e.zero));
    end
    if (streamMode) begin
      if (haveLast) checkEq("stream_gap", 128'(cycleNo - lastOut), 128'd1);
      lastOut  = cycleNo;
      haveLast = 1'b1;
    end
  endtask

  task automatic tick();
    #1;
    if (obsValid && outRdy) checkOutput();
    accepted = inValid && obsInReady;
    if (accepted) begin
      sb.push_back(model(inA, inB, inCin, inSub));
      nPushed++;
    end
    @(posedge clk);
    cycleNo++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(logic [127:0] a, logic [127:0] b, logic cin, logic sub,
                               output int ticks);
    inA     = a & maskW(curW);
    inB     = b & maskW(curW);
    inCin   = cin;
    inSub   = sub;
    inValid = 1'b1;
    ticks   = 0;
    accepted = 1'b0;
    while (!accepted && ticks < 20) begin
      tick();
      ticks++;
    end
    checkEq("accept", 128'(accepted), 128'd1);
  endtask

  task automatic waitOutput(output int n);
    inValid = 1'b0;
    n = 0;
    while (!obsValid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    int n;
    inValid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    checkEq("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  // One beat in an empty pipe: latency, then outputs against hand-derived constants.
  task automatic directed(string tag, logic [127:0] a, logic [127:0] b, logic cin, logic sub,
                          logic [127:0] expSum, logic expCout, logic expOvf);
    int t, lat;
    applyStimulus(a, b, cin, sub, t);
    waitOutput(lat);
    checkEq({tag, "_latency"}, 128'(lat + 1), 128'(curSt));
    checkEq({tag, "_sum"},  obsSum, expSum);
    checkEq({tag, "_cout"}, 128'(obsCout), 128'(expCout));
    checkEq({tag, "_ovf"},  128'(obsOvf),  128'(expOvf));
    checkEq({tag, "_zero"}, 128'(obsZero), 128'(expSum == 128'b0));
    tick();
  endtask

  task automatic runSuite(int c);
    int           t, lat;
    logic [127:0] m, msb, snap;

    cfg   = c;
    curW  = (c == 0) ? 128 : 64;
    curSt = (c == 0) ? 4 : 1;
    m     = maskW(curW);
    msb   = 128'd1 << (curW - 1);
    nPushed = 0; nPopped = 0; nDiscard = 0;
    sb.delete();
    $display("[TB] suite WIDTH=%0d STAGES=%0d", curW, curSt);

    inValid = 1'b0; outRdy = 1'b1; inA = '0; inB = '0; inCin = 1'b0; inSub = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    checkEq("rst_valid",   128'(obsValid),   128'd0);
    checkEq("rst_sum",     obsSum,           128'd0);
    checkEq("rst_cout",    128'(obsCout),    128'd0);
    checkEq("rst_ovf",     128'(obsOvf),     128'd0);
    checkEq("rst_zero",    128'(obsZero),    128'd1);
    checkEq("rst_inready", 128'(obsInReady), 128'd1);
    rst_n = 1'b1;
    @(negedge clk);

    directed("max_add",   m, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
    directed("sub_5_7",   128'd5, 128'd7, 1'b0, 1'b1, m - 128'd1, 1'b0, 1'b0);
    directed("ovf_add",   msb - 128'd1, 128'd1, 1'b0, 1'b0, msb, 1'b0, 1'b1);
    directed("ovf_sub",   msb, 128'd1, 1'b0, 1'b1, msb - 128'd1, 1'b1, 1'b1);
    directed("sub_cin",   128'd10, 128'd3, 1'b1, 1'b1, 128'd7, 1'b1, 1'b0);
    directed("cin_chain", m, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1, 1'b0);
    directed("seg_bound", 128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0, 128'h1_0000_0000, 1'b0, 1'b0);

    streamMode = 1'b1;
    haveLast   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(rand128(), rand128(), 1'($urandom_range(1)), 1'(i % 2), t);
      checkEq("stream_accept", 128'(t), 128'd1);
    end
    drain();
    streamMode = 1'b0;

    outRdy = 1'b0;
    for (int i = 0; i < curSt; i++) begin
      applyStimulus(rand128(), rand128(), 1'b0, 1'(i % 2), t);
    end
    inA = rand128() & m; inB = rand128() & m; inCin = 1'b1; inSub = 1'b0; inValid = 1'b1;
    #1;
    snap = obsSum;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkEq("stall_inready", 128'(obsInReady), 128'd0);
      checkEq("stall_valid",   128'(obsValid),   128'd1);
      checkEq("stall_sum",     obsSum,           snap);
      @(posedge clk); @(negedge clk);
    end
    outRdy = 1'b1;
    applyStimulus(inA, inB, inCin, inSub, t);
    checkEq("release_accept", 128'(t), 128'd1);
    drain();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(rand128(), rand128(), 1'b0, 1'b0, t);
    end
    inValid = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkEq("midrst_valid", 128'(obsValid), 128'd0);
    checkEq("midrst_sum",   obsSum,         128'd0);
    checkEq("midrst_cout",  128'(obsCout),  128'd0);
    checkEq("midrst_ovf",   128'(obsOvf),   128'd0);
    checkEq("midrst_zero",  128'(obsZero),  128'd1);
    nDiscard += sb.size();
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    directed("post_rst", 128'd1, 128'd1, 1'b0, 1'b0, 128'd2, 1'b0, 1'b0);

    waitOutput(lat);
    checkEq("no_stray_output", 128'(obsValid), 128'd0);
    checkEq("beats_balance", 128'(nPopped + nDiscard), 128'(nPushed));
  endtask

  initial begin
    nTests = 0; nFails = 0; cycleNo = 0; lastOut = 0;
    streamMode = 1'b0; haveLast = 1'b0; accepted = 1'b0;
    cfg = 0; curW = 128; curSt = 4;
    inValid = 1'b0; outRdy = 1'b1; inA = '0; inB = '0; inCin = 1'b0; inSub = 1'b0;
    rst_n = 1'b0;
    runSuite(0);
    runSuite(1);
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
